// File: rtl/icache_fetch_ctrl.sv
// IF-stage icache sequencer: hit path, byte-wide miss refill, cache fill.
// ICACHE_FILL_FORWARD_EN: answer IF directly from the fill buffer.
module icache_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_valid_o,
  output logic [31:0]           if_inst_o,
  output logic [ADDR_WIDTH-1:0] cache_raddr_o,
  input  logic                  cache_hit_i,
  input  logic [31:0]           cache_inst_i,
  output logic                  cache_we_o,
  output logic [ADDR_WIDTH-1:0] cache_waddr_o,
  output logic [31:0]           cache_winst_o,
  output logic                  mem_req_o,
  input  logic                  mem_grant_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [7:0]            mem_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    READ,
    FILL
  } state_e;

  localparam logic [1:0] LAST = 2'(FETCH_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            cnt_q;
  logic                  pend_q;
  logic [31:0]           buf_q;
  logic                  if_valid_q;
  logic [31:0]           if_inst_q;
  logic                  cache_we_q;
  logic [ADDR_WIDTH-1:0] cache_waddr_q;
  logic [31:0]           cache_winst_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  assign cache_raddr_o = (state_q == IDLE) ? if_addr_i : addr_q;
  assign if_valid_o    = if_valid_q & rdy;
  // a flush arriving in the fill cycle still kills the write
  assign cache_we_o    = cache_we_q & rdy & ~flush_i;
  assign if_inst_o     = if_inst_q;
  assign cache_waddr_o = cache_waddr_q;
  assign cache_winst_o = cache_winst_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      buf_q         <= '0;
      if_valid_q    <= 1'b0;
      if_inst_q     <= '0;
      cache_we_q    <= 1'b0;
      cache_waddr_q <= '0;
      cache_winst_q <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else if (rdy) begin
      if_valid_q <= 1'b0;
      cache_we_q <= 1'b0;
      if (flush_i) begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // a live if_valid_q means IF is still holding the answered req
            if (if_req_i && !if_valid_q) begin
              if (cache_hit_i) begin
                if_valid_q <= 1'b1;
                if_inst_q  <= cache_inst_i;
              end else begin
                addr_q    <= if_addr_i;
                mem_req_q <= 1'b1;
                state_q   <= WAIT_GNT;
              end
            end
          end
          WAIT_GNT: begin
            if (mem_grant_i) begin
              mem_addr_q <= addr_q;
              cnt_q      <= '0;
              pend_q     <= 1'b0;
              buf_q      <= '0;
              state_q    <= READ;
            end
          end
          READ: begin
            if (!pend_q) begin
              pend_q     <= 1'b1;
              mem_addr_q <= addr_q + ONE;
            end else begin
              buf_q[{cnt_q, 3'b000} +: 8] <= mem_data_i;
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q < 2'd2) begin
                mem_addr_q <= addr_q + TWO +
                              {{(ADDR_WIDTH-2){1'b0}}, cnt_q};
              end
              if (cnt_q == LAST) begin
                mem_req_q     <= 1'b0;
                cache_we_q    <= 1'b1;
                cache_waddr_q <= addr_q;
                cache_winst_q <= {mem_data_i, buf_q[23:0]};
                state_q       <= FILL;
              end
            end
          end
          FILL: begin
            state_q <= IDLE;
`ifdef ICACHE_FILL_FORWARD_EN
            if (if_req_i) begin
              if_valid_q <= 1'b1;
              if_inst_q  <= buf_q;
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Scoreboard bench for icache_fetch_ctrl with cache, memory and arbiter models.
module tb_icache_fetch_ctrl;

`ifdef ICACHE_FILL_FORWARD_EN
  localparam int MISS_LAT = 8;
`else
  localparam int MISS_LAT = 9;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] cache_raddr_o;
  logic        cache_hit_i;
  logic [31:0] cache_inst_i;
  logic        cache_we_o;
  logic [31:0] cache_waddr_o;
  logic [31:0] cache_winst_o;
  logic        mem_req_o;
  logic        mem_grant_i;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i = '0;

  always #5 clk = ~clk;

  icache_fetch_ctrl #(.ADDR_WIDTH(32), .FETCH_BYTES(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_valid_o(if_valid_o), .if_inst_o(if_inst_o),
    .cache_raddr_o(cache_raddr_o), .cache_hit_i(cache_hit_i),
    .cache_inst_i(cache_inst_i), .cache_we_o(cache_we_o),
    .cache_waddr_o(cache_waddr_o), .cache_winst_o(cache_winst_o),
    .mem_req_o(mem_req_o), .mem_grant_i(mem_grant_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i)
  );

  // byte memory, one-cycle read latency, frozen with the core
  logic [7:0] mem [0:255];
  always @(posedge clk) if (rdy) mem_data_i <= mem[mem_addr_o[7:0]];

  // direct-mapped cache model, full-address tag
  bit        cv [64];
  bit [31:0] ct [64];
  bit [31:0] cd [64];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (cache_we_o) begin
      cv[cache_waddr_o[7:2]] <= 1'b1;
      ct[cache_waddr_o[7:2]] <= cache_waddr_o;
      cd[cache_waddr_o[7:2]] <= cache_winst_o;
    end else if (pre_we) begin
      cv[pre_addr[7:2]] <= 1'b1;
      ct[pre_addr[7:2]] <= pre_addr;
      cd[pre_addr[7:2]] <= pre_data;
    end
  end
  assign cache_hit_i  = cv[cache_raddr_o[7:2]] &&
                        ct[cache_raddr_o[7:2]] == cache_raddr_o;
  assign cache_inst_i = cd[cache_raddr_o[7:2]];

  // arbiter: grants after gnt_dly cycles of request
  int req_age = 0;
  int gnt_dly = 0;
  always @(posedge clk) req_age <= mem_req_o ? req_age + 1 : 0;
  assign mem_grant_i = mem_req_o && (req_age >= gnt_dly);

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  logic [31:0] exp_inst [$];
  logic [63:0] exp_we [$];
  logic [31:0] exp_addr [$];
  int  ncyc = 0;
  int  resp_cnt = 0;
  int  req_hits = 0;
  bit  amon_en = 1'b0;
  bit  have_last = 1'b0;
  bit  gnt_prev = 1'b0;
  logic [31:0] last_addr = '0;

  always @(negedge clk) begin
    logic [63:0] w;
    ncyc++;
    if (mem_req_o) req_hits++;
    if (if_valid_o) begin
      resp_cnt++;
      if (exp_inst.size() == 0)
        chk("resp_unexp", {31'b0, if_valid_o}, 32'd0);
      else
        chk("resp_inst", if_inst_o, exp_inst.pop_front());
    end
    if (cache_we_o) begin
      if (exp_we.size() == 0)
        chk("we_unexp", {31'b0, cache_we_o}, 32'd0);
      else begin
        w = exp_we.pop_front();
        chk("we_addr", cache_waddr_o, w[63:32]);
        chk("we_data", cache_winst_o, w[31:0]);
      end
    end
    if (!amon_en) have_last = 1'b0;
    else if (mem_req_o && gnt_prev &&
             (!have_last || mem_addr_o != last_addr)) begin
      if (exp_addr.size() == 0)
        chk("addr_extra", mem_addr_o, 32'hFFFF_FFFF);
      else
        chk("addr_seq", mem_addr_o, exp_addr.pop_front());
      last_addr = mem_addr_o;
      have_last = 1'b1;
    end
    gnt_prev = mem_grant_i;
  end

  int t0 = 0;
  int r0 = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] inst,
                       input bit miss, input bit keep);
    if (keep) begin
      exp_inst.push_back(inst);
      if (miss) exp_we.push_back({a, inst});
    end
    if_addr_i = a;
    if_req_i  = 1'b1;
    t0 = ncyc;
    r0 = resp_cnt;
  endtask

  task automatic wait_resp(input string tag, input int lat);
    for (int i = 0; i < 80 && resp_cnt == r0; i++) tick(1);
    chk({tag, "_resp"}, 32'(resp_cnt - r0), 32'd1);
    chk({tag, "_lat"}, 32'(ncyc - t0), 32'(lat));
    if_req_i = 1'b0;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + i] = w[8*i +: 8];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put_word(32'h20, 32'h0010_0513);
    put_word(32'h40, 32'h0010_0513);
    put_word(32'h60, 32'hCAFE_F00D);
    put_word(32'h80, 32'h0010_0513);
    put_word(32'hA0, 32'h0010_0513);

    tick(2);
    chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);
    chk("rst_we", {31'b0, cache_we_o}, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);
    chk("rst_winst", cache_winst_o, 32'd0);
    rst = 1'b0;
    tick(1);

    pre_addr = 32'h10;
    pre_data = 32'h00A0_0093;
    pre_we   = 1'b1;
    tick(1);
    pre_we   = 1'b0;

    begin
      int rq = req_hits;
      start(32'h10, 32'h00A0_0093, 1'b0, 1'b1);
      wait_resp("hit", 1);
      tick(1);
      chk("hit_noreq", 32'(req_hits - rq), 32'd0);
    end

    start(32'h20, 32'h0010_0513, 1'b1, 1'b1);
    wait_resp("miss", MISS_LAT);
    tick(1);
    chk("miss_fill", 32'(exp_we.size()), 32'd0);
    start(32'h20, 32'h0010_0513, 1'b0, 1'b1);
    wait_resp("rehit", 1);
    tick(1);

    gnt_dly = 3;
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'h40 + 32'(i));
    amon_en = 1'b1;
    start(32'h40, 32'h0010_0513, 1'b1, 1'b1);
    wait_resp("gnt_dly", MISS_LAT + 3);
    amon_en = 1'b0;
    gnt_dly = 0;
    chk("addr_left", 32'(exp_addr.size()), 32'd0);
    tick(1);

    start(32'h60, 32'hCAFE_F00D, 1'b1, 1'b0);
    tick(5);
    flush_i  = 1'b1;
    if_req_i = 1'b0;
    tick(1);
    flush_i  = 1'b0;
    chk("flush_req", {31'b0, mem_req_o}, 32'd0);
    chk("flush_valid", {31'b0, if_valid_o}, 32'd0);
    chk("flush_we", {31'b0, cache_we_o}, 32'd0);
    tick(12);
    chk("flush_nofill", {31'b0, cv[6'h18]}, 32'd0);
    start(32'h60, 32'hCAFE_F00D, 1'b1, 1'b1);
    wait_resp("refetch", MISS_LAT);
    tick(1);

    start(32'h80, 32'h0010_0513, 1'b1, 1'b1);
    tick(3);
    rdy = 1'b0;
    tick(4);
    rdy = 1'b1;
    wait_resp("rdy_stall", MISS_LAT + 4);
    tick(1);

    start(32'hA0, 32'h0010_0513, 1'b1, 1'b0);
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, mem_req_o}, 32'd0);
    chk("arst_maddr", mem_addr_o, 32'd0);
    chk("arst_we", {31'b0, cache_we_o}, 32'd0);
    chk("arst_valid", {31'b0, if_valid_o}, 32'd0);
    if_req_i = 1'b0;
    tick(1);
    #2;
    rst = 1'b0;
    tick(12);
    chk("arst_nofill", {31'b0, cv[6'h28]}, 32'd0);
    start(32'h10, 32'h00A0_0093, 1'b0, 1'b1);
    wait_resp("arst_hit", 1);
    tick(2);
    chk("inst_left", 32'(exp_inst.size()), 32'd0);
    chk("we_left", 32'(exp_we.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
